// File: rtl/pipelined_cla_adder_if.sv
// pipelined_cla_adder_if: operand/result handshake bundle for pipelined_cla_adder
interface pipelined_cla_adder_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;
  modport master (output in_valid, a, b, c_in, sub, out_ready,
                  input  in_ready, out_valid, s, c_out, ovf);
  modport slave  (input  in_valid, a, b, c_in, sub, out_ready,
                  output in_ready, out_valid, s, c_out, ovf);
endinterface

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: STAGES-deep adder/subtractor built from 4-bit CLA slices; signed overflow only with CLA_ADDER_OVF_EN
module pipelined_cla_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic clk,
  input logic rst_n,
  pipelined_cla_adder_if.slave bus
);
  localparam int SEG    = WIDTH / STAGES;
  localparam int SLICES = SEG / 4;

  logic             advance;
  logic [WIDTH-1:0] bp;
  logic             cin;

  assign advance     = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;
  assign bp          = bus.sub ? ~bus.b : bus.b;
  assign cin         = bus.sub | bus.c_in;

  // returns {group generate, group propagate, 4-bit sum} with all internal carries looked ahead
  function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [3:0] g, p, c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]), &p, p ^ c};
  endfunction

  genvar k;
  for (k = 0; k < STAGES; k++) begin : stg
    localparam int W = WIDTH - k * SEG;
    logic [W-1:0]           a_in, b_in;
    logic                   c_in_s, v_in;
    logic [SEG-1:0]         ss;
    logic [SLICES:0]        gc;
    logic [5:0]             r;
    logic [(k+1)*SEG-1:0]   sum_d, sum_q;
    logic                   v_q, c_q;
`ifdef CLA_ADDER_OVF_EN
    logic                   am_in, bm_in, am_q, bm_q;
`endif
    if (k == 0) begin : head
      assign a_in   = bus.a;
      assign b_in   = bp;
      assign c_in_s = cin;
      assign v_in   = bus.in_valid;
      assign sum_d  = ss;
`ifdef CLA_ADDER_OVF_EN
      assign am_in  = bus.a[WIDTH-1];
      assign bm_in  = bp[WIDTH-1];
`endif
    end else begin : link
      assign a_in   = stg[k-1].ops.a_q;
      assign b_in   = stg[k-1].ops.b_q;
      assign c_in_s = stg[k-1].c_q;
      assign v_in   = stg[k-1].v_q;
      assign sum_d  = {ss, stg[k-1].sum_q};
`ifdef CLA_ADDER_OVF_EN
      assign am_in  = stg[k-1].am_q;
      assign bm_in  = stg[k-1].bm_q;
`endif
    end
    // segment adder: CLA slices chained through their group generate/propagate
    always_comb begin
      gc    = '0;
      ss    = '0;
      r     = '0;
      gc[0] = c_in_s;
      for (int j = 0; j < SLICES; j++) begin
        r            = cla4(a_in[4*j +: 4], b_in[4*j +: 4], gc[j]);
        ss[4*j +: 4] = r[3:0];
        gc[j+1]      = r[5] | (r[4] & gc[j]);
      end
    end
    // stage register: valid, segment carry and the bit-aligned partial sum move together on advance
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (advance) begin
        v_q   <= v_in;
        c_q   <= gc[SLICES];
        sum_q <= sum_d;
      end
    end
`ifdef CLA_ADDER_OVF_EN
    // operand sign bits travel with the beat for the final overflow test
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        am_q <= 1'b0;
        bm_q <= 1'b0;
      end else if (advance) begin
        am_q <= am_in;
        bm_q <= bm_in;
      end
    end
`endif
    if (k < STAGES - 1) begin : ops
      logic [W-SEG-1:0] a_q, b_q;
      // operand bits not yet added are passed to the next stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_in[W-1:SEG];
          b_q <= b_in[W-1:SEG];
        end
      end
    end
  end

  assign bus.out_valid = stg[STAGES-1].v_q;
  assign bus.s         = stg[STAGES-1].sum_q;
  assign bus.c_out     = stg[STAGES-1].c_q;
`ifdef CLA_ADDER_OVF_EN
  assign bus.ovf = (stg[STAGES-1].am_q == stg[STAGES-1].bm_q) && (bus.s[WIDTH-1] != stg[STAGES-1].am_q);
`else
  assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: scoreboard bench for 16-bit/4-stage and 4-bit/1-stage adders
module tb_pipelined_cla_adder;
  localparam int STAGES = 4;
`ifdef CLA_ADDER_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_cla_adder_if #(.WIDTH(16)) bus ();
  pipelined_cla_adder_if #(.WIDTH(4))  bus4 ();

  pipelined_cla_adder #(.WIDTH(16), .STAGES(STAGES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  pipelined_cla_adder #(.WIDTH(4),  .STAGES(1))      dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          cyc;
    bit          exact;
  } exp_t;

  exp_t sb[$];
  exp_t sb4[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb_,
                      input logic [15:0] s_exp, input logic c_exp, input logic o_exp, input bit exact);
    exp_t e;
    int n;
    bus.a = a; bus.b = b; bus.c_in = ci; bus.sub = sb_; bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("accept_timeout", 32'd0, 32'd1);
    else begin
      e.s = s_exp; e.c = c_exp; e.o = o_exp & OVF; e.cyc = cyc; e.exact = exact;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    exp_t e;
    logic [4:0] sum;
    int n;
    bus4.a = a; bus4.b = b; bus4.c_in = ci; bus4.in_valid = 1'b1;
    sum = {1'b0, a} + {1'b0, b} + {4'd0, ci};
    n = 0;
    @(negedge clk);
    while (!bus4.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus4.in_ready) chk("accept4_timeout", 32'd0, 32'd1);
    else begin
      e.s = {12'd0, sum[3:0]}; e.c = sum[4];
      e.o = OVF & (a[3] == b[3]) & (sum[3] != a[3]);
      e.cyc = cyc; e.exact = 1'b1;
      sb4.push_back(e);
    end
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (sb.size() != 0 || sb4.size() != 0); i++) @(negedge clk);
    chk("drain", 32'(sb.size() + sb4.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // 16-bit result monitor: compares every presented cycle, pops on transfer
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && bus.out_valid) begin
      if (sb.size() == 0) chk("spurious_out", 32'd1, 32'd0);
      else begin
        e = sb[0];
        chk("result", {14'd0, bus.ovf, bus.c_out, bus.s}, {14'd0, e.o, e.c, e.s});
        if (bus.out_ready) begin
          void'(sb.pop_front());
          if (e.exact) chk("latency", 32'(cyc - e.cyc), 32'(STAGES));
        end
      end
    end
  end

  // 4-bit result monitor
  always @(negedge clk) begin : mon4
    exp_t e;
    if (rst_n && bus4.out_valid) begin
      if (sb4.size() == 0) chk("spurious_out4", 32'd1, 32'd0);
      else begin
        e = sb4[0];
        chk("result4", {26'd0, bus4.ovf, bus4.c_out, bus4.s}, {26'd0, e.o, e.c, e.s[3:0]});
        if (bus4.out_ready) begin
          void'(sb4.pop_front());
          chk("latency4", 32'(cyc - e.cyc), 32'd1);
        end
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0; bus.sub = 1'b0; bus.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.c_in = 1'b0; bus4.sub = 1'b0; bus4.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_s", {16'd0, bus.s}, 32'd0);
    chk("rst_c_out", {31'd0, bus.c_out}, 32'd0);
    chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // a, b, c_in, sub, s, c_out, ovf
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    send(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    send(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'h000A, 16'h0003, 1'b1, 1'b1, 16'h0007, 1'b1, 1'b0, 1'b1);
    send(16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    send(16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    drain();
    // stall: downstream refuses the first result for two cycles
    bus.out_ready = 1'b0;
    send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    send(16'h0002, 16'h0002, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b0);
    send(16'h0003, 16'h0003, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
    chk("stall_valid1", {31'd0, bus.out_valid}, 32'd1);
    chk("stall_ready1", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_ready2", {31'd0, bus.in_ready}, 32'd0);
    chk("stall_hold", {16'd0, bus.s}, 32'h0002);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drain();
    // reset with two beats in flight
    send(16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b1);
    send(16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("mid_rst_s", {16'd0, bus.s}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(16'h0011, 16'h0022, 1'b0, 1'b0, 16'h0033, 1'b0, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", {31'd0, bus.out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    drain();
    // 4-bit, single-stage exhaustive addition
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int ci = 0; ci < 2; ci++)
          send4(4'(a), 4'(b), 1'(ci));
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
